// File: rtl/bch_chien_search.sv
// Stallable Chien search for shortened binary BCH codes: evaluates sigma at BITS
// consecutive field points per beat and streams per-bit error flags plus a root-count verdict.
module bch_chien_search #(
  parameter logic [31:0] P    = {8'd4, 8'd2, 16'd7},  // {M[7:0], T[7:0], DATA_BITS[15:0]}
  parameter int          BITS = 1,
  localparam int M         = int'(P[31:24]),
  localparam int T         = int'(P[23:16]),
  localparam int DATA_BITS = int'(P[15:0]),
  localparam int CNT_W     = ($clog2(T + 1) < 1) ? 1 : $clog2(T + 1)
) (
  input  logic                 i_clk,
  input  logic                 i_reset_n,
  input  logic                 i_start,
  output logic                 o_ready,
  input  logic [(T+1)*M-1:0]   i_sigma,
  output logic                 o_err_valid,
  input  logic                 i_err_ready,
  output logic [BITS-1:0]      o_err,
  output logic                 o_err_first,
  output logic                 o_err_last,
  output logic                 o_done,
  output logic [CNT_W-1:0]     o_err_count,
  output logic                 o_fail
);

  localparam int N         = (1 << M) - 1;
  localparam int K         = N - M * T;
  localparam int E0        = K - DATA_BITS + 1;
  localparam int CYCLES    = (DATA_BITS + BITS - 1) / BITS;
  localparam int LAST_BITS = DATA_BITS - (CYCLES - 1) * BITS;
  localparam int BEAT_W    = (CYCLES > 1) ? $clog2(CYCLES) : 1;
  localparam int RC_W      = $clog2(T + BITS + 2);

  function automatic int prim_poly(input int m);
    case (m)
      3:       return 'h3;
      4:       return 'h3;
      5:       return 'h5;
      6:       return 'h3;
      7:       return 'h9;
      8:       return 'h1D;
      9:       return 'h11;
      10:      return 'h9;
      11:      return 'h5;
      12:      return 'h53;
      13:      return 'h1B;
      14:      return 'h443;
      15:      return 'h3;
      16:      return 'h100B;
      default: return 'h3;
    endcase
  endfunction

  localparam int          PRIM = prim_poly(M);
  localparam logic [M-1:0] POLY = PRIM[M-1:0];

  function automatic logic [M-1:0] gf_mul(input logic [M-1:0] a, input logic [M-1:0] b);
    logic [M-1:0] r;
    r = '0;
    for (int i = M - 1; i >= 0; i--) begin
      r = {r[M-2:0], 1'b0} ^ (r[M-1] ? POLY : '0);
      if (b[i]) r = r ^ a;
    end
    return r;
  endfunction

  function automatic logic [M-1:0] gf_alpha_pow(input int k);
    logic [M-1:0] r;
    r = M'(1);
    for (int j = 0; j < k; j++) r = gf_mul(r, M'(2));
    return r;
  endfunction

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_REPORT} state_t;
  state_t r_state, w_state_next;

  logic [M-1:0]       r_lane [T+1];
  logic [M-1:0]       w_lane_load [T+1];
  logic [M-1:0]       w_lane_adv [T+1];
  logic [M-1:0]       w_term [BITS][T+1];
  logic [BEAT_W-1:0]  r_beat;
  logic [RC_W-1:0]    r_root_cnt;
  logic [CNT_W-1:0]   r_deg;
  logic [CNT_W-1:0]   r_err_count;
  logic               r_fail;
  logic [CNT_W-1:0]   w_deg;
  logic [BITS-1:0]    w_root;
  logic [RC_W-1:0]    w_pop, w_cnt_sum, w_cnt_next;
  logic               w_accept, w_xfer, w_beat_last;

  // Per-lane constant multipliers: seed offset, per-beat stride, per-bit evaluation point.
  for (genvar gi = 0; gi <= T; gi++) begin : g_lane
    localparam logic [M-1:0] C_LOAD = gf_alpha_pow((gi * E0) % N);
    localparam logic [M-1:0] C_ADV  = gf_alpha_pow((gi * BITS) % N);
    assign w_lane_load[gi] = gf_mul(i_sigma[gi*M +: M], C_LOAD);
    assign w_lane_adv[gi]  = gf_mul(r_lane[gi], C_ADV);
    for (genvar gb = 0; gb < BITS; gb++) begin : g_bit
      localparam logic [M-1:0] C_EVAL = gf_alpha_pow((gi * gb) % N);
      assign w_term[gb][gi] = gf_mul(r_lane[gi], C_EVAL);
    end
  end

  assign w_accept    = (r_state == S_IDLE) && i_start;
  assign w_xfer      = (r_state == S_RUN) && i_err_ready;
  assign w_beat_last = (r_beat == BEAT_W'(CYCLES - 1));

  always_comb begin
    logic [M-1:0] acc;
    w_root = '0;
    w_pop  = '0;
    for (int b = 0; b < BITS; b++) begin
      acc = '0;
      for (int i = 0; i <= T; i++) acc = acc ^ w_term[b][i];
      // Tail bits of the last beat lie outside the shortened data region.
      w_root[b] = (acc == '0) && (r_state == S_RUN) && (!w_beat_last || (b < LAST_BITS));
      w_pop = w_pop + RC_W'(w_root[b]);
    end
    w_cnt_sum  = r_root_cnt + w_pop;
    w_cnt_next = (w_cnt_sum > RC_W'(T)) ? RC_W'(T + 1) : w_cnt_sum;
  end

  always_comb begin
    w_deg = '0;
    for (int i = 1; i <= T; i++) begin
      if (i_sigma[i*M +: M] != '0) w_deg = CNT_W'(i);
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) r_state <= S_IDLE;
    else            r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    o_ready      = 1'b0;
    o_err_valid  = 1'b0;
    o_done       = 1'b0;
    case (r_state)
      S_IDLE: begin
        o_ready = 1'b1;
        if (i_start) w_state_next = S_RUN;
      end
      S_RUN: begin
        o_err_valid = 1'b1;
        if (i_err_ready && w_beat_last) w_state_next = S_REPORT;
      end
      S_REPORT: begin
        o_done       = 1'b1;
        w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      for (int i = 0; i <= T; i++) r_lane[i] <= '0;
      r_beat      <= '0;
      r_root_cnt  <= '0;
      r_deg       <= '0;
      r_err_count <= '0;
      r_fail      <= 1'b0;
    end else if (w_accept) begin
      for (int i = 0; i <= T; i++) r_lane[i] <= w_lane_load[i];
      r_beat      <= '0;
      r_root_cnt  <= '0;
      r_deg       <= w_deg;
      r_err_count <= '0;
      r_fail      <= 1'b0;
    end else if (w_xfer) begin
      for (int i = 0; i <= T; i++) r_lane[i] <= w_lane_adv[i];
      r_beat     <= r_beat + BEAT_W'(1);
      r_root_cnt <= w_cnt_next;
      if (w_beat_last) begin
        // Counter parks at T+1 once it overflows, so any excess still reads as a mismatch.
        r_err_count <= (w_cnt_next > RC_W'(T)) ? CNT_W'(T) : CNT_W'(w_cnt_next);
        r_fail      <= (w_cnt_next != RC_W'(r_deg));
      end
    end
  end

  assign o_err       = w_root;
  assign o_err_first = (r_state == S_RUN) && (r_beat == '0);
  assign o_err_last  = (r_state == S_RUN) && w_beat_last;
  assign o_err_count = r_err_count;
  assign o_fail      = r_fail;

endmodule

// File: tb/tb_bch_chien_search.sv
// Bench for bch_chien_search: two instances (BITS=1 and BITS=3) checked every cycle against
// a direct polynomial-evaluation model over GF(16).
module tb_bch_chien_search;
  localparam logic [31:0] PP = {8'd4, 8'd2, 16'd7};
  localparam int T = 2, DB = 7, E0 = 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, start, err_ready, sel;
  logic [11:0] sigma;
  logic        r1, v1, f1, l1, d1, fl1, r3, v3, f3, l3, d3, fl3;
  logic [0:0]  e1;
  logic [2:0]  e3;
  logic [1:0]  c1, c3;

  bch_chien_search #(.P(PP), .BITS(1)) dut1 (
    .i_clk(clk), .i_reset_n(rst_n), .i_start(start & ~sel), .o_ready(r1), .i_sigma(sigma),
    .o_err_valid(v1), .i_err_ready(err_ready), .o_err(e1), .o_err_first(f1), .o_err_last(l1),
    .o_done(d1), .o_err_count(c1), .o_fail(fl1));

  bch_chien_search #(.P(PP), .BITS(3)) dut3 (
    .i_clk(clk), .i_reset_n(rst_n), .i_start(start & sel), .o_ready(r3), .i_sigma(sigma),
    .o_err_valid(v3), .i_err_ready(err_ready), .o_err(e3), .o_err_first(f3), .o_err_last(l3),
    .o_done(d3), .o_err_count(c3), .o_fail(fl3));

  wire       m_ready = sel ? r3 : r1;
  wire       m_valid = sel ? v3 : v1;
  wire [2:0] m_err   = sel ? e3 : {2'b00, e1};
  wire       m_first = sel ? f3 : f1;
  wire       m_last  = sel ? l3 : l1;
  wire       m_done  = sel ? d3 : d1;
  wire [1:0] m_cnt   = sel ? c3 : c1;
  wire       m_fail  = sel ? fl3 : fl1;

  int n_cmp = 0, n_bad = 0;

  task automatic check(input string nm, input int got, input int want);
    n_cmp++;
    if (got != want) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, got, want, $time);
    end
  endtask

  // GF(16) log/antilog tables, x^4+x+1
  int alog[15];
  int lg[16];

  function automatic int gmul(input int a, input int b);
    if (a == 0 || b == 0) return 0;
    return alog[(lg[a] + lg[b]) % 15];
  endfunction

  function automatic int sig_eval(input int s0, input int s1, input int s2, input int e);
    return s0 ^ gmul(s1, alog[e % 15]) ^ gmul(s2, alog[(2 * e) % 15]);
  endfunction

  int exp_beats[$];
  int exp_ncyc, exp_cnt, exp_fail, exp_deg, exp_raw;

  task automatic build_model(input int s0, input int s1, input int s2, input int bits);
    int beat;
    exp_beats.delete();
    exp_raw  = 0;
    exp_ncyc = (DB + bits - 1) / bits;
    for (int c = 0; c < exp_ncyc; c++) begin
      beat = 0;
      for (int b = 0; b < bits; b++) begin
        if (c * bits + b < DB && sig_eval(s0, s1, s2, E0 + c * bits + b) == 0) begin
          beat = beat | (1 << b);
          exp_raw++;
        end
      end
      exp_beats.push_back(beat);
    end
    exp_deg  = (s2 != 0) ? 2 : ((s1 != 0) ? 1 : 0);
    exp_cnt  = (exp_raw > T) ? T : exp_raw;
    exp_fail = (exp_raw != exp_deg) ? 1 : 0;
  endtask

  // Monitor: checks every cycle against the expectations latched when a start is accepted.
  int  mon_beats[$];
  int  mon_ncyc, mon_cnt, mon_fail, beat_idx, act_cyc;
  bit  active = 0, pend = 0, done_due = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      active = 0; pend = 0; done_due = 0;
    end else begin
      if (pend) begin
        active = 1; pend = 0; beat_idx = 0; act_cyc = 0;
        mon_beats = exp_beats; mon_ncyc = exp_ncyc; mon_cnt = exp_cnt; mon_fail = exp_fail;
      end
      if (done_due) begin
        done_due = 0;
        check("done_pulse", m_done, 1);
        check("err_count", m_cnt, mon_cnt);
        check("fail_flag", m_fail, mon_fail);
        check("valid_in_report", m_valid, 0);
        check("ready_in_report", m_ready, 0);
      end else if (active) begin
        act_cyc++;
        check("valid_run", m_valid, 1);
        check("ready_run", m_ready, 0);
        check("done_run", m_done, 0);
        if (m_valid) begin
          check("err_beat", m_err, mon_beats[beat_idx]);
          check("err_first", m_first, (beat_idx == 0) ? 1 : 0);
          check("err_last", m_last, (beat_idx == mon_ncyc - 1) ? 1 : 0);
          if (err_ready) begin
            if (beat_idx == mon_ncyc - 1) begin
              active = 0; done_due = 1;
            end
            beat_idx++;
          end
        end
        if (active && act_cyc > 400) begin
          check("run_timeout", 0, 1);
          active = 0;
        end
      end else begin
        check("idle_done", m_done, 0);
        check("idle_valid", m_valid, 0);
        check("idle_ready", m_ready, 1);
        if (start && m_ready) pend = 1;
      end
    end
  end

  int word_no = 0;

  task automatic run_word(input int sl, input int s0, input int s1, input int s2,
                          input bit stall, input int abort_at);
    build_model(s0, s1, s2, sl ? 3 : 1);
    sel   = sl[0];
    sigma = {s2[3:0], s1[3:0], s0[3:0]};
    for (int k = 0; k < 30 && !m_ready; k++) begin
      @(posedge clk); #1;
    end
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 0; k < 300; k++) begin
      err_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      if (k == abort_at) rst_n = 1'b0;
      @(posedge clk); #1;
      if (k == abort_at) begin
        rst_n = 1'b1;
        break;
      end
      if (m_done) break;
    end
    err_ready = 1'b1;
    @(posedge clk); #1;
    $display("word %0d bits=%0d sigma=%03h stall=%0d abort=%0d exp_cnt=%0d exp_fail=%0d",
             word_no, sl ? 3 : 1, sigma, stall, abort_at, exp_cnt, exp_fail);
    word_no++;
  endtask

  initial begin
    int a, i, j, s1, s2;
    a = 1;
    for (int k = 0; k < 15; k++) begin
      alog[k] = a; lg[a] = k;
      a = a << 1;
      if ((a & 16) != 0) a = a ^ 'h13;
    end
    lg[0] = 0;
    rst_n = 1'b0; start = 1'b0; err_ready = 1'b1; sel = 1'b0; sigma = 12'h001;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    check("rst_cnt1", c1, 0);  check("rst_fail1", fl1, 0); check("rst_err1", e1, 0);
    check("rst_cnt3", c3, 0);  check("rst_fail3", fl3, 0); check("rst_err3", e3, 0);
    check("rst_ready3", r3, 1); check("rst_first3", f3, 0); check("rst_last3", l3, 0);

    // 1: sigma = 1
    build_model(1, 0, 0, 1);
    check("pin_t1_deg", exp_deg, 0); check("pin_t1_fail", exp_fail, 0);
    run_word(0, 1, 0, 0, 0, -1);

    // 2: single root at e=5 -> beat 4
    build_model(1, alog[10], 0, 1);
    check("pin_t2_beat4", exp_beats[4], 1); check("pin_t2_cnt", exp_raw, 1);
    run_word(0, 1, alog[10], 0, 0, -1);

    // 3: roots at e=1 and e=6 with BITS=3
    s1 = alog[14] ^ alog[9];
    s2 = alog[(14 + 9) % 15];
    build_model(1, s1, s2, 3);
    check("pin_t3_b0", exp_beats[0], 1); check("pin_t3_b1", exp_beats[1], 4);
    check("pin_t3_b2", exp_beats[2], 0); check("pin_t3_cnt", exp_cnt, 2);
    run_word(1, 1, s1, s2, 0, -1);

    // 4: irreducible quadratic, no roots anywhere in the field
    build_model(1, 1, alog[3], 3);
    a = 0;
    for (int e = 0; e < 15; e++) if (sig_eval(1, 1, alog[3], e) == 0) a++;
    check("pin_t4_allroots", a, 0); check("pin_t4_fail", exp_fail, 1);
    run_word(1, 1, 1, alog[3], 0, -1);

    // 5: test 3 under random backpressure
    for (int r = 0; r < 4; r++) run_word(1, 1, s1, s2, 1, -1);

    // 6: abort during beat 2, then a clean run of the same word
    run_word(0, 1, alog[10], 0, 0, 2);
    run_word(0, 1, alog[10], 0, 0, -1);
    run_word(1, 1, s1, s2, 0, 1);
    run_word(1, 1, s1, s2, 1, -1);

    // Random words: product-of-roots locators and arbitrary coefficients
    for (int r = 0; r < 60; r++) begin
      if ($urandom_range(0, 1) == 1) begin
        i  = $urandom_range(0, 14);
        j  = $urandom_range(0, 14);
        s1 = alog[i] ^ alog[j];
        s2 = alog[(i + j) % 15];
      end else begin
        s1 = $urandom_range(0, 15);
        s2 = $urandom_range(0, 15);
      end
      run_word($urandom_range(0, 1), 1, s1, s2, 1'($urandom_range(0, 1)), -1);
    end

    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish, compared %0d", n_cmp);
    $fatal(1, "timeout");
  end

endmodule
